conv_controller: RTL and testbench
==================================

CONV_CONTROLLER -- requirements
Module: conv_controller

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The module SHALL have the following ports, each named and described below.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- sample_load_en  in  1  a new sample is ready for loading.
- new_row  in  1  discard the current sample window and restart the row.
- coeff_load_en  in  1  request to load 3 coefficients.
- modwait  out  1  busy, high during any load state.
- sample_stream  out  1  stream the sample window into the datapath.
- sample_shift  out  1  shift one sample into the window.
- convolve_en  out  1  accumulate one product this cycle.
- coeff_ld  out  1  write the coefficient register selected by coeff_sel.
- coeff_sel  out  2  coefficient index, 0..2.
REQ-003 All outputs SHALL be registered or decoded from the registered state only (Moore machine).

Function
REQ-004 The FSM SHALL have these states: IDLE, LOAD_C0, LOAD_C1, LOAD_C2, LOAD_S0, WAIT_S1, LOAD_S1, WAIT_S2, LOAD_S2, CONV0, CONV1, CONV2, CONV_WAIT, LOAD_SN.
REQ-005 Output decode SHALL be as follows; any output not listed is 0.
- IDLE / WAIT_* / CONV_WAIT: all outputs 0.
- LOAD_Cn: modwait=1, coeff_ld=1, coeff_sel=n.
- LOAD_S0/S1/S2/SN: modwait=1, sample_shift=1.
- CONVn: convolve_en=1, sample_stream=1, coeff_sel=n, modwait=0.
REQ-006 From IDLE, the FSM SHALL move to LOAD_C0 if coeff_load_en=1 (highest priority), else to LOAD_S0 if sample_load_en=1, else stay in IDLE.
REQ-007 The coefficient states SHALL advance unconditionally LOAD_C0 -> LOAD_C1 -> LOAD_C2 -> IDLE, one cycle each, with inputs ignored.
REQ-008 Every LOAD_S state SHALL last exactly one cycle and go unconditionally to the next state.
- LOAD_S0 -> WAIT_S1.
- LOAD_S1 -> WAIT_S2.
- LOAD_S2 -> CONV0.
- LOAD_SN -> CONV0.
REQ-009 Because of REQ-008, a sample_load_en held high continuously SHALL produce load, wait, load, wait (one wait cycle minimum between loads).
REQ-010 In WAIT_S1 and WAIT_S2, new_row=1 SHALL go to IDLE (priority); otherwise sample_load_en=1 SHALL go to LOAD_S1 or LOAD_S2 respectively; otherwise the FSM SHALL hold indefinitely.
REQ-011 The convolution states SHALL advance unconditionally CONV0 -> CONV1 -> CONV2 -> CONV_WAIT, with inputs ignored during CONVn.
REQ-012 In CONV_WAIT the FSM SHALL take the first matching transition below, else hold.
- new_row=1 -> IDLE.
- coeff_load_en=1 -> LOAD_C0.
- sample_load_en=1 -> LOAD_SN.
REQ-013 A coefficient reload from CONV_WAIT SHALL end in IDLE, so a full 3-sample reload is needed before convolving again.
REQ-014 Latency: an input sampled at rising edge k SHALL be reflected in the outputs after edge k.
REQ-015 coeff_load_en and sample_load_en SHALL be ignored in every state not listed in REQ-006, REQ-010 and REQ-012.

Reset
REQ-016 While rst=1 the state SHALL be IDLE and all outputs 0 immediately, with no clock edge required.
REQ-017 Asserting rst in the middle of any sequence SHALL abort it.
REQ-018 After rst is released, the first transition SHALL occur on the next rising edge.

Structure
REQ-019 A shared package conv_pkg SHALL hold the state enum type (4-bit encoding) and a localparam NUM_COEFF=3.
REQ-020 The module SHALL be a single FSM, consisting of a state register and next-state/output logic; no sub-module is required.

Verification
REQ-021 Reset: rst=1 for half a cycle, then 1.5 cycles more -> all outputs 0 both times; release at a negedge -> still all 0.
REQ-022 Coefficient load: coeff_load_en=1 for one cycle from IDLE -> three cycles of modwait=1, coeff_ld=1, with coeff_sel 0, 1, 2; then all outputs 0.
REQ-023 Sample load with sample_load_en held high for 3 cycles.
- Cycle 1 (S0): modwait=1, sample_shift=1.
- Cycle 2 (WAIT_S1): all outputs 0.
- Cycle 3 (S1): modwait=1, sample_shift=1.
- Then drop sample_load_en: WAIT_S2, all 0, held for 3+ cycles.
- Re-assert sample_load_en: S2, modwait=1, sample_shift=1.
REQ-024 Convolution: the cycle after LOAD_S2 -> convolve_en=1, sample_stream=1, coeff_sel=0, modwait=0; then coeff_sel 1, then 2; then CONV_WAIT with all outputs 0.
REQ-025 Streaming and new row.
- In CONV_WAIT, pulse sample_load_en -> one LOAD_SN cycle (modwait=1, sample_shift=1), then CONV0..CONV2.
- In CONV_WAIT, pulse new_row -> IDLE; the next sample_load_en -> LOAD_S0.
REQ-026 Priority and async reset.
- new_row and sample_load_en both 1 in WAIT_S2 -> IDLE.
- rst asserted during CONV1 -> all outputs 0 at once.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_pkg                                                             |
// | Shared state, control-word types and decode for conv_controller.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conv_pkg;

    localparam int NUM_COEFF   = 3;
    localparam int COEFF_SEL_W = $clog2(NUM_COEFF);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_C0   = 4'd1,
        LOAD_C1   = 4'd2,
        LOAD_C2   = 4'd3,
        LOAD_S0   = 4'd4,
        WAIT_S1   = 4'd5,
        LOAD_S1   = 4'd6,
        WAIT_S2   = 4'd7,
        LOAD_S2   = 4'd8,
        CONV0     = 4'd9,
        CONV1     = 4'd10,
        CONV2     = 4'd11,
        CONV_WAIT = 4'd12,
        LOAD_SN   = 4'd13
    } conv_state_t;

    typedef struct packed {
        logic                   modwait;
        logic                   sample_stream;
        logic                   sample_shift;
        logic                   convolve_en;
        logic                   coeff_ld;
        logic [COEFF_SEL_W-1:0] coeff_sel;
    } conv_ctrl_t;

    // Control word that is presented while the FSM sits in a given state.
    function automatic conv_ctrl_t decode_ctrl(input conv_state_t state);
        conv_ctrl_t ctrl;
        ctrl = '0;
        case (state)
            LOAD_C0: begin ctrl.modwait = 1'b1; ctrl.coeff_ld = 1'b1; ctrl.coeff_sel = COEFF_SEL_W'(0); end
            LOAD_C1: begin ctrl.modwait = 1'b1; ctrl.coeff_ld = 1'b1; ctrl.coeff_sel = COEFF_SEL_W'(1); end
            LOAD_C2: begin ctrl.modwait = 1'b1; ctrl.coeff_ld = 1'b1; ctrl.coeff_sel = COEFF_SEL_W'(2); end
            LOAD_S0, LOAD_S1, LOAD_S2, LOAD_SN: begin
                ctrl.modwait      = 1'b1;
                ctrl.sample_shift = 1'b1;
            end
            CONV0: begin ctrl.convolve_en = 1'b1; ctrl.sample_stream = 1'b1; ctrl.coeff_sel = COEFF_SEL_W'(0); end
            CONV1: begin ctrl.convolve_en = 1'b1; ctrl.sample_stream = 1'b1; ctrl.coeff_sel = COEFF_SEL_W'(1); end
            CONV2: begin ctrl.convolve_en = 1'b1; ctrl.sample_stream = 1'b1; ctrl.coeff_sel = COEFF_SEL_W'(2); end
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_controller                                                      |
// | Moore FSM sequencing coefficient loads, sample loads and convolution.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_controller
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_load_en,
    input  logic       new_row,
    input  logic       coeff_load_en,
    output logic       modwait,
    output logic       sample_stream,
    output logic       sample_shift,
    output logic       convolve_en,
    output logic       coeff_ld,
    output logic [1:0] coeff_sel
);

    conv_state_t r_state;
    conv_state_t w_next;
    conv_ctrl_t  r_ctrl;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (coeff_load_en)       w_next = LOAD_C0;
                else if (sample_load_en) w_next = LOAD_S0;
            end
            LOAD_C0: w_next = LOAD_C1;
            LOAD_C1: w_next = LOAD_C2;
            LOAD_C2: w_next = IDLE;
            LOAD_S0: w_next = WAIT_S1;
            WAIT_S1: begin
                if (new_row)             w_next = IDLE;
                else if (sample_load_en) w_next = LOAD_S1;
            end
            LOAD_S1: w_next = WAIT_S2;
            WAIT_S2: begin
                if (new_row)             w_next = IDLE;
                else if (sample_load_en) w_next = LOAD_S2;
            end
            LOAD_S2: w_next = CONV0;
            CONV0:   w_next = CONV1;
            CONV1:   w_next = CONV2;
            CONV2:   w_next = CONV_WAIT;
            // A coefficient reload here drops the window, so the row restarts from IDLE.
            CONV_WAIT: begin
                if (new_row)             w_next = IDLE;
                else if (coeff_load_en)  w_next = LOAD_C0;
                else if (sample_load_en) w_next = LOAD_SN;
            end
            LOAD_SN: w_next = CONV0;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
        end
    end

    assign modwait       = r_ctrl.modwait;
    assign sample_stream = r_ctrl.sample_stream;
    assign sample_shift  = r_ctrl.sample_shift;
    assign convolve_en   = r_ctrl.convolve_en;
    assign coeff_ld      = r_ctrl.coeff_ld;
    assign coeff_sel     = r_ctrl.coeff_sel;

endmodule
`default_nettype wire

// File: tb/tb_conv_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_controller                                                   |
// | Self-checking bench: directed scenarios plus randomized model check. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_conv_controller;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       sample_load_en;
    logic       new_row;
    logic       coeff_load_en;
    logic       modwait;
    logic       sample_stream;
    logic       sample_shift;
    logic       convolve_en;
    logic       coeff_ld;
    logic [1:0] coeff_sel;
    logic [6:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: {modwait, sample_stream, sample_shift, convolve_en, coeff_ld, coeff_sel}
    localparam logic [6:0] ZERO  = 7'b0000000;
    localparam logic [6:0] SHIFT = 7'b1010000;
    localparam logic [6:0] C0    = 7'b1000100;
    localparam logic [6:0] C1    = 7'b1000101;
    localparam logic [6:0] C2    = 7'b1000110;
    localparam logic [6:0] V0    = 7'b0101000;
    localparam logic [6:0] V1    = 7'b0101001;
    localparam logic [6:0] V2    = 7'b0101010;

    assign outs = {modwait, sample_stream, sample_shift, convolve_en, coeff_ld, coeff_sel};

    always #5 tb_clk = ~tb_clk;

    conv_controller dut (
        .clk            (tb_clk),
        .rst            (rst),
        .sample_load_en (sample_load_en),
        .new_row        (new_row),
        .coeff_load_en  (coeff_load_en),
        .modwait        (modwait),
        .sample_stream  (sample_stream),
        .sample_shift   (sample_shift),
        .convolve_en    (convolve_en),
        .coeff_ld       (coeff_ld),
        .coeff_sel      (coeff_sel)
    );

    // Reference model: tracks what activity is underway and how full the window is.
    int m_coeff;   // coefficient being written this cycle, -1 when none
    int m_conv;    // product being accumulated this cycle, -1 when none
    int m_have;    // samples currently held in the window
    bit m_shift;   // a sample is being shifted in this cycle

    task automatic model_reset();
        m_coeff = -1;
        m_conv  = -1;
        m_have  = 0;
        m_shift = 1'b0;
    endtask

    task automatic model_step(input logic sl, input logic nr, input logic cl);
        if (m_coeff >= 0) begin
            m_coeff = (m_coeff == 2) ? -1 : m_coeff + 1;
        end else if (m_conv >= 0) begin
            m_conv = (m_conv == 2) ? -1 : m_conv + 1;
        end else if (m_shift) begin
            m_shift = 1'b0;
            if (m_have == 3) m_conv = 0;
        end else if (m_have == 0) begin
            if (cl)      m_coeff = 0;
            else if (sl) begin m_shift = 1'b1; m_have = 1; end
        end else if (m_have < 3) begin
            if (nr)      m_have = 0;
            else if (sl) begin m_shift = 1'b1; m_have = m_have + 1; end
        end else begin
            if (nr)      m_have = 0;
            else if (cl) begin m_have = 0; m_coeff = 0; end
            else if (sl) m_shift = 1'b1;
        end
    endtask

    function automatic logic [6:0] model_out();
        if (m_coeff >= 0) return {5'b10001, 2'(m_coeff)};
        if (m_conv >= 0)  return {5'b01010, 2'(m_conv)};
        if (m_shift)      return SHIFT;
        return ZERO;
    endfunction

    task automatic tick(input logic sl, input logic nr, input logic cl);
        sample_load_en = sl;
        new_row        = nr;
        coeff_load_en  = cl;
        @(posedge tb_clk);
        model_step(sl, nr, cl);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sample_load_en = 1'b0;
        new_row        = 1'b0;
        coeff_load_en  = 1'b0;
        model_reset();
        @(negedge tb_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_load_en = 1'b0;
        new_row        = 1'b0;
        coeff_load_en  = 1'b0;
        model_reset();
        #5;
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL reset_half: got %b expected %b", outs, ZERO); end
        #15;
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", outs, ZERO); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL reset_release: got %b expected %b", outs, ZERO); end
        @(posedge tb_clk);
        #1;
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL reset_first_edge: got %b expected %b", outs, ZERO); end
    endtask

    task automatic test_coeff_load();
        logic [9:0] seq [5] = '{{3'b001, C0}, {3'b100, C1}, {3'b110, C2}, {3'b000, ZERO}, {3'b000, ZERO}};
        for (int i = 0; i < 5; i++) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            n_checks++;
            if (outs !== seq[i][6:0]) begin
                n_fail++;
                $display("FAIL coeff_load step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
        end
    endtask

    task automatic test_sample_load();
        logic [9:0] seq [9] = '{{3'b100, SHIFT}, {3'b100, ZERO}, {3'b100, SHIFT}, {3'b000, ZERO},
                               {3'b000, ZERO}, {3'b000, ZERO}, {3'b001, ZERO}, {3'b000, ZERO},
                               {3'b100, SHIFT}};
        for (int i = 0; i < 9; i++) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            n_checks++;
            if (outs !== seq[i][6:0]) begin
                n_fail++;
                $display("FAIL sample_load step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
        end
    endtask

    task automatic test_convolution();
        logic [9:0] seq [5] = '{{3'b000, V0}, {3'b111, V1}, {3'b111, V2}, {3'b000, ZERO}, {3'b000, ZERO}};
        for (int i = 0; i < 5; i++) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            n_checks++;
            if (outs !== seq[i][6:0]) begin
                n_fail++;
                $display("FAIL convolution step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
        end
    endtask

    task automatic test_stream_new_row();
        logic [9:0] seq [8] = '{{3'b100, SHIFT}, {3'b000, V0}, {3'b000, V1}, {3'b000, V2},
                               {3'b000, ZERO}, {3'b010, ZERO}, {3'b100, SHIFT}, {3'b000, ZERO}};
        for (int i = 0; i < 8; i++) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            n_checks++;
            if (outs !== seq[i][6:0]) begin
                n_fail++;
                $display("FAIL stream_new_row step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
        end
    endtask

    task automatic test_priority();
        logic [9:0] seq [22] = '{{3'b100, SHIFT}, {3'b000, ZERO}, {3'b110, ZERO}, {3'b001, C0},
                                {3'b000, C1}, {3'b000, C2}, {3'b000, ZERO}, {3'b100, SHIFT},
                                {3'b100, ZERO}, {3'b100, SHIFT}, {3'b100, ZERO}, {3'b100, SHIFT},
                                {3'b000, V0}, {3'b000, V1}, {3'b000, V2}, {3'b000, ZERO},
                                {3'b101, C0}, {3'b000, C1}, {3'b000, C2}, {3'b000, ZERO},
                                {3'b100, SHIFT}, {3'b000, ZERO}};
        for (int i = 0; i < 22; i++) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            n_checks++;
            if (outs !== seq[i][6:0]) begin
                n_fail++;
                $display("FAIL priority step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] seq [5] = '{{3'b100, SHIFT}, {3'b000, ZERO}, {3'b100, SHIFT}, {3'b000, V0}, {3'b000, V1}};
        for (int i = 0; i < 5; i++) begin
            tick(seq[i][9], seq[i][8], seq[i][7]);
            n_checks++;
            if (outs !== seq[i][6:0]) begin
                n_fail++;
                $display("FAIL async_reset lead-in step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL async_reset_conv1: got %b expected %b", outs, ZERO); end
        @(negedge tb_clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL async_reset_release: got %b expected %b", outs, ZERO); end
        tick(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== SHIFT) begin n_fail++; $display("FAIL async_reset_first_load: got %b expected %b", outs, SHIFT); end
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== ZERO) begin n_fail++; $display("FAIL async_reset_wait_s1: got %b expected %b", outs, ZERO); end
    endtask

    task automatic test_random();
        logic sl;
        logic nr;
        logic cl;
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                model_reset();
                #1;
                n_checks++;
                if (outs !== ZERO) begin
                    n_fail++;
                    $display("FAIL random_reset cycle %0d: got %b expected %b", cyc, outs, ZERO);
                end
                @(negedge tb_clk);
                rst = 1'b0;
            end else begin
                sl = ($urandom_range(0, 99) < 55);
                nr = ($urandom_range(0, 99) < 8);
                cl = ($urandom_range(0, 99) < 10);
                tick(sl, nr, cl);
                n_checks++;
                if (outs !== model_out()) begin
                    n_fail++;
                    $display("FAIL random cycle %0d: got %b expected %b (in sl=%b nr=%b cl=%b)",
                             cyc, outs, model_out(), sl, nr, cl);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_coeff_load();
        test_sample_load();
        test_convolution();
        test_stream_new_row();
        test_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
